// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: one full-adder slice reused over WIDTH cycles,
// with start/busy/done handshake and held Sum/Carry result registers.

module serial_adder_ctrl_fa (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ c_i;
  assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q, sum_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, carry_q, busy_q, done_q;
  logic             slice_s, slice_co;
  logic [WIDTH-1:0] acc_d;

  serial_adder_ctrl_fa u_slice (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (c_q),
    .s_o (slice_s),
    .co_o(slice_co)
  );

  // Result bits enter at the MSB and walk down, so after WIDTH steps bit 0 is LSB.
  generate
    if (WIDTH == 1) begin : g_acc1
      assign acc_d = slice_s;
    end else begin : g_accn
      assign acc_d = {slice_s, acc_q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            c_q     <= Cin;
            cnt_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q  <= acc_d;
          c_q    <= slice_co;
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q   <= acc_d;
            carry_q <= slice_co;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign Sum   = sum_q;
  assign Carry = carry_q;
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial addition sequencer. One single-bit full-adder slice (Sum = a^b^c, Carry = a&b | c&(a^b)) is reused across WIDTH clock cycles to add two WIDTH-bit operands. FSM, operand shift registers, carry flip-flop and bit counter live here. Start/busy/done handshake to the surrounding lab top level.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 1..32

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  request to add; sampled only in IDLE
A  input  WIDTH  operand A; captured on the accepting edge
B  input  WIDTH  operand B; captured on the accepting edge
Cin  input  1  carry-in; captured on the accepting edge
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse: Sum/Carry just updated
Sum  output  WIDTH  registered result, held between operations
Carry  output  1  registered carry-out, held between operations

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset (async, any state incl. mid-operation): state=IDLE; shift regs, carry FF, counter, Sum, Carry = 0; busy=0; done=0. Aborted operation produces no done.
- States: IDLE, RUN, DONE.
- IDLE: on edge E0 with start=1, latch a_sh<=A, b_sh<=B, c<=Cin, cnt<=0, acc<=0, go RUN. start=0: stay. Operand changes in IDLE have no effect.
- RUN, edges E1..EWIDTH, one bit per edge: slice inputs a_sh[0], b_sh[0], c. acc <= {slice_sum, acc[WIDTH-1:1]}. c <= slice_carry. a_sh and b_sh shift right by 1. cnt <= cnt+1.
- RUN exit: on the edge where cnt==WIDTH-1 (EWIDTH), Sum <= final acc value including this bit, Carry <= slice_carry, go DONE.
- DONE: done=1 for exactly this one cycle. Next edge goes to IDLE.
- Latency: done high during cycle after EWIDTH, i.e. WIDTH cycles after the accepting edge. busy high for WIDTH+1 cycles (RUN+DONE).
- Next start can be accepted at EWIDTH+2 at the earliest.
- start while busy (RUN or DONE) is ignored, not queued. A/B/Cin changes during RUN do not affect the result.
- Arithmetic: {Carry,Sum} = A + B + Cin, modulo 2^(WIDTH+1). Unsigned; no overflow flag.
- Sum/Carry change only on the EWIDTH edge or on reset. They hold their value through IDLE and through the next operation's RUN.
- Counter width: max(1, clog2(WIDTH)).
- WIDTH=1: RUN lasts one edge; done appears one cycle after accept.
- done and busy are registered or decoded from the state register only; no combinational path from start.

Test Plan:
- WIDTH=8, reset then A=0x35, B=0x4A, Cin=0, start 1 cycle -> busy=1 next cycle; done pulse exactly 8 cycles after accept; Sum=0x7F, Carry=0; busy=0 after done.
- A=0xFF, B=0x01, Cin=0 -> Sum=0x00, Carry=1. Then A=0xFF, B=0xFF, Cin=1 -> Sum=0xFF, Carry=1. Then A=0x80, B=0x80, Cin=0 -> Sum=0x00, Carry=1.
- Hold start=1 continuously with A=0x10, B=0x20 -> one op per 10 cycles (accept, 8 RUN, DONE, re-accept in IDLE). Each result 0x30; exactly one done pulse per op.
- Mid-RUN (cycle 4), change A/B to 0xAA/0x55 and pulse start -> ignored. Result still from originally latched operands; no extra done.
- Assert rst at RUN cycle 5 (async, mid-cycle) -> busy, done, Sum, Carry go 0 immediately with no clock. After release, a new op 0x01+0x02 -> Sum=0x03, Carry=0.
- WIDTH=1 build: A=1, B=1, Cin=1 -> done 1 cycle after accept; Sum=1, Carry=1.
